// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one FP multiplier between the execute stage (port 0) and
// the divide/sqrt sequencer (port 1); an owner tag rides alongside the multiplier.
module fp_mul_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int STAGES = MUL_LATENCY;

    logic              ptr;
    logic              accept;
    logic              contested;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   own_pipe;

    // ptr names the port that wins when both ask in the same cycle
    assign req0_ready = !stall && req0_valid && (!req1_valid || !ptr);
    assign req1_ready = !stall && req1_valid && (!req0_valid || ptr);
    assign accept     = req0_ready || req1_ready;
    assign contested  = accept && req0_valid && req1_valid;
    assign busy       = |vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (contested) begin
            ptr <= ~ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= req1_ready ? req1_a : req0_a;
            mul_b <= req1_ready ? req1_b : req0_b;
        end
    end

    // Tag pipe never stalls: the multiplier itself has no hold capability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            own_pipe <= {own_pipe[STAGES-1:0], req1_ready};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp0_valid <= vld_pipe[STAGES] && !own_pipe[STAGES];
            rsp1_valid <= vld_pipe[STAGES] &&  own_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                rsp_data <= mul_result;
            end
        end
    end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares the single-precision FloatingPointMultiplier between two requesters: the integer/FP execute stage (port 0) and the FP divide/sqrt microsequencer (port 1). It arbitrates round-robin, registers the winning operand pair into the multiplier, tracks an owner tag through a pipeline matched to the multiplier latency, and returns each result to its owner as a one-cycle response. It sits between the execute stage and the multiplier instance in the FP unit.

## Interface
- MUL_LATENCY, default 1: clock edges from the multiplier sampling `mul_a`/`mul_b` to `mul_result` being valid; legal range 1..8.
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  when high, no new request is granted
- req0_valid  in  1  requester 0 has operands
- req0_a, req0_b  in  32  requester 0 IEEE-754 single operands
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  as port 0, for requester 1
- mul_a, mul_b  out  32  operands driven to multiplier `a`/`b`
- mul_result  in  32  multiplier `result`
- rsp0_valid, rsp1_valid  out  1  one-cycle response strobe per requester
- rsp_data  out  32  product, shared by both response ports
- busy  out  1  any operation accepted and not yet responded

## Operation
- Handshake: request N is accepted on an edge where reqN_valid & reqN_ready. `reqN_ready` is combinational from valids, stall and the priority pointer; at most one ready is high per cycle.
- Arbitration: stall=1 → both ready low. Only one valid → that one granted. Both valid → port at the priority pointer granted. Pointer moves to the other port after every contested grant; unchanged otherwise. Reset pointer = 0.
- Issue register: on accept, operands captured into `mul_a`/`mul_b`; held unchanged when nothing is accepted.
- Tag pipe: MUL_LATENCY+1 stages of {valid, owner}. Stage 0 loads {1, N} on accept, {0, x} otherwise; shifts every cycle, no stall (the multiplier cannot stall).
- Response register: at the last stage, captures `mul_result` into `rsp_data` and pulses rsp{owner}_valid for one cycle. No response backpressure; requesters must consume on the strobe.
- Arbiter never modifies operands or result bits (sign, NaN, denormal passed through).
- Throughput: one accept per cycle; unlimited outstanding up to pipe depth.
- `busy` = OR of all tag-pipe valid bits.

## Timing
- Reset values: mul_a = mul_b = 0, rsp_data = 0, rsp0_valid = rsp1_valid = 0, busy = 0, all tag valids 0, pointer 0. Ready outputs follow inputs combinationally after reset.
- Accept at edge E → mul_a/mul_b valid after E → rspN_valid and rsp_data valid in the cycle after edge E+MUL_LATENCY+1. With MUL_LATENCY=1: response appears after edge E+2.
- Responses return in accept order; back-to-back accepts give back-to-back responses, possibly alternating owners.
- Stall asserted: in-flight operations still complete and respond on schedule.
- Reset mid-operation: all in-flight operations are discarded, with no response. The pointer returns to 0.
- req valid dropped without handshake: legal, no effect. Operands need only be stable in the accept cycle.

## Test plan
- Single port 0: a=0x3F000000, b=0x3F000000 → req0_ready same cycle; rsp0_valid one cycle after accept edge+2 with rsp_data=0x3E800000; rsp1_valid stays 0; busy high for 2 cycles.
- Sign case on port 1: a=0x3F000000, b=0xBEE00000 → rsp1_valid, rsp_data=0xBE600000; then a=b=0xBF400000 → 0x3F100000.
- Contention: both valid, held for 4 cycles, after reset → grants 0,1,0,1; responses strobe rsp0,rsp1,rsp0,rsp1 on consecutive cycles with matching products.
- Stall: both valid, stall=1 for 3 cycles → no ready. An op accepted before the stall still responds on schedule. After stall drops, the grant goes to the pointer port.
- Reset mid-flight: accept at edge E, assert rst before E+2 → no rsp strobe, busy=0, mul_a=mul_b=0, rsp_data=0.
- MUL_LATENCY=3 build with a 3-stage multiplier model: response arrives after edge E+4; 4 back-to-back accepts return in order.
